// File: rtl/regfile_wb_arbiter_pkg.sv
// regfile_wb_arbiter_pkg: shared widths and requester identifiers for the writeback arbiter.
package regfile_wb_arbiter_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 5;
    localparam int NUM_REGS       = 2 ** DEF_ADDR_WIDTH;

    typedef enum logic {
        GNT_REQ0 = 1'b0,
        GNT_REQ1 = 1'b1
    } req_id_e;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin grant; every grant is a transfer, so last_grant follows any grant.
module rr_arb2
    import regfile_wb_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] valid_i,
    output logic [1:0] gnt_o
);

    req_id_e last_q, last_d;

    always_comb begin
        gnt_o  = &valid_i ? (last_q == GNT_REQ1 ? 2'b01 : 2'b10) : valid_i;
        last_d = gnt_o[1] ? GNT_REQ1 : (gnt_o[0] ? GNT_REQ0 : last_q);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) last_q <= GNT_REQ1;
        else        last_q <= last_d;
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin share of the register-file write port between two
// writeback requesters, with a registered write stage and a pending-write scoreboard.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req0_valid,
    input  logic [ADDR_WIDTH-1:0]    req0_addr,
    input  logic [DATA_WIDTH-1:0]    req0_data,
    output logic                     req0_ready,
    input  logic                     req1_valid,
    input  logic [ADDR_WIDTH-1:0]    req1_addr,
    input  logic [DATA_WIDTH-1:0]    req1_data,
    output logic                     req1_ready,
    input  logic                     rsv_valid,
    input  logic [ADDR_WIDTH-1:0]    rsv_addr,
    output logic                     regWrite,
    output logic [ADDR_WIDTH-1:0]    reg_write_address,
    output logic [DATA_WIDTH-1:0]    data_wb,
    output logic [2**ADDR_WIDTH-1:0] pending
);

    localparam int NREGS = 2 ** ADDR_WIDTH;
    localparam logic [NREGS-1:0] ONE = NREGS'(1);

    logic [1:0]            gnt;
    logic                  xfer;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  wr_q, wr_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [NREGS-1:0]      pend_q, pend_d, clr, set;

    rr_arb2 u_arb (
        .clk     (clk),
        .reset   (reset),
        .valid_i ({req1_valid, req0_valid}),
        .gnt_o   (gnt)
    );

    assign req0_ready = gnt[0];
    assign req1_ready = gnt[1];

    always_comb begin
        xfer     = |gnt;
        sel_addr = gnt[1] ? req1_addr : req0_addr;
        sel_data = gnt[1] ? req1_data : req0_data;
        // writes to register 0 are accepted but never reach the register file
        wr_d     = xfer && (sel_addr != '0);
        addr_d   = xfer ? sel_addr : addr_q;
        data_d   = xfer ? sel_data : data_q;
        clr      = wr_q ? ONE << addr_q : '0;
        set      = (rsv_valid && rsv_addr != '0) ? ONE << rsv_addr : '0;
        // set is applied after clear so a same-cycle new reservation survives
        pend_d   = (pend_q & ~clr) | set;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            pend_q <= '0;
        end else begin
            wr_q   <= wr_d;
            addr_q <= addr_d;
            data_q <= data_d;
            pend_q <= pend_d;
        end
    end

    assign regWrite          = wr_q;
    assign reg_write_address = addr_q;
    assign data_wb           = data_q;
    assign pending           = pend_q;

endmodule
